seq_pattern_detector: RTL
=========================

# seq_pattern_detector

Parametrised serial pattern detector: a runtime-loadable, W-bit generalisation of the single-pattern pulse FSM. Samples one bit per valid cycle, compares the last W sampled bits against a loaded pattern, and emits a registered one-cycle match pulse (Moore style). Supports overlapping and non-overlapping detection, and optionally a saturating match counter. Sits between serial front-end logic (line decoders, sync-word search) and control FSMs that consume the match event.

## Interface
- W, default 4: pattern length in bits; legal range 2..16.
- CNT_W, default 8: match counter width; legal range 1..32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  capture `pattern` and `overlap` and flush history.
- pattern  in  W  pattern to detect; first-received bit is `pattern[W-1]`.
- overlap  in  1  mode: 1 = overlapping (MODE_OVERLAP), 0 = non-overlapping.
- in_valid  in  1  `x` is sampled only when high.
- x  in  1  serial data bit.
- clear  in  1  zero the match counter (counter build only).
- match  out  1  registered one-cycle pulse on detection.
- armed  out  1  history holds W valid bits (fill == W).
- match_count  out  CNT_W  saturating match count (counter build only).

## Operation
- Internal state: `pat_q` (W), `mode_q` (1), history shift register `hist` (W), fill counter `fill` (0..W, saturating), `match` register, optional `cnt` register.
- Reset: `pat_q`=0, `mode_q`=MODE_OVERLAP, `hist`=0, `fill`=0, `match`=0, `armed`=0, `match_count`=0.
- Load: `pat_q`<=pattern, `mode_q`<=overlap, `hist`<=0, `fill`<=0, `match`<=0. Load has priority over `in_valid`; the bit presented in the load cycle is discarded.
- Sample (in_valid=1, load=0): `hist`<={hist[W-2:0], x}; `fill`<=min(fill+1, W).
- Match condition is evaluated on the post-shift values: new fill == W and new hist == `pat_q`.
  - On a hit, `match`<=1.
  - MODE_NONOVERLAP: on a hit, `fill`<=0. The next match needs W fresh bits.
  - MODE_OVERLAP: `fill` stays at W. Suffix bits can start the next match.
- `match`<=0 in any cycle without a hit, including in_valid=0 cycles.
- `armed` = (fill == W), registered.
- Counter: +1 on each hit, saturates at 2^CNT_W-1.
  - `clear` zeroes it.
  - clear together with a hit: the counter ends at 0, and `match` still pulses.
  - load does not affect the counter.
- Reset mid-stream: all state returns to reset values on the next edge, and the partial history is lost.

## Timing
- Latency: `match` rises in the cycle after the edge that samples the last pattern bit. It is high for exactly one cycle per hit.
- Back-to-back hits, e.g. pattern 1111 in overlap mode on consecutive valid cycles, hold `match` high for consecutive cycles.
- `match_count` updates on the same edge as `match`.
- `pattern` and `overlap` are don't-care except in load cycles.

## Configuration
- Macro: SEQ_PATTERN_DETECTOR_COUNT_EN.
- Defined: counter logic, `clear` and `match_count` ports are present.
- Undefined: no counter register, and the `clear` and `match_count` ports are absent. All other behaviour is identical.

## Structure
- Package `seq_det_pkg` holds:
  - `det_mode_e` enum {MODE_NONOVERLAP=1'b0, MODE_OVERLAP=1'b1};
  - constants W_MIN=2, W_MAX=16, CNT_W_MAX=32.
- The top module uses `det_mode_e` for `mode_q`.
- Sub-module `sat_counter` (parameter CNT_W; inputs inc, clr; output count) implements the saturating match counter. It is instantiated only under the macro.
- Parameter range is checked with elaboration-time assertions.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1, x=1 -> match=0, armed=0, match_count=0 throughout.
- Overlap detection: W=4, load 1011, overlap=1, stream 1,0,1,1,0,1,1 -> match pulses after bit 4 and bit 7; match_count=2.
- Non-overlap detection: same stream with overlap=0 -> single match after bit 4; match_count=1; armed=0 after the hit.
- Valid gaps: 1011 sent with in_valid=0 idle cycles between bits, x toggling while idle -> exactly one match, one cycle after the 4th valid bit.
- Load mid-stream and ignored bit: after 3 bits of 1011, load 0110 with in_valid=1 -> history flushed and that bit ignored; then 0,1,1,0 -> one match.
- Saturation and clear: CNT_W=2, pattern 1111 in overlap mode, 6 consecutive 1s -> match high 3 consecutive cycles; match_count stops at 3. Then clear -> count 0.

Source files
------------

// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and limits for the serial pattern detector.
//   det_mode_e : detection mode (non-overlapping / overlapping)
//   W_MIN/W_MAX: legal pattern length range
//   CNT_W_MAX  : widest supported match counter
package seq_det_pkg;

    typedef enum logic {
        MODE_NONOVERLAP = 1'b0,
        MODE_OVERLAP    = 1'b1
    } det_mode_e;

    localparam int W_MIN     = 2;
    localparam int W_MAX     = 16;
    localparam int CNT_W_MAX = 32;

endpackage : seq_det_pkg

// File: rtl/seq_pattern_detector_if.sv
// Control/data bundle between the serial front end (master) and the
// pattern detector (slave).
//   load, pattern[W], overlap : configuration capture
//   in_valid, x               : serial bit stream
//   match, armed              : detector status
//   clear, match_count[CNT_W] : counter control/status, present only when
//                               SEQ_PATTERN_DETECTOR_COUNT_EN is defined
interface seq_pattern_detector_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic         load;
    logic [W-1:0] pattern;
    logic         overlap;
    logic         in_valid;
    logic         x;
    logic         match;
    logic         armed;
`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
    logic             clear;
    logic [CNT_W-1:0] match_count;
`endif

    modport master (
`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
        output clear,
        input  match_count,
`endif
        output load, pattern, overlap, in_valid, x,
        input  match, armed
    );

    modport slave (
`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
        input  clear,
        output match_count,
`endif
        input  load, pattern, overlap, in_valid, x,
        output match, armed
    );

endinterface : seq_pattern_detector_if

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter used to count pattern hits.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one event (ignored once at the maximum value)
//   clr      : zero the counter; wins over inc
//   count    : registered count value
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if ((CNT_W < 1) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
        $error("sat_counter: CNT_W out of range");
    end

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Next count: clear first, then saturating increment.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign count = cnt_r;

endmodule : sat_counter

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector. Shifts in one bit per valid cycle and raises a
// registered one-cycle match pulse when the last W bits equal the loaded
// pattern (first-received bit compared against pattern[W-1]).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_pattern_detector_if.slave (load/pattern/overlap,
//              in_valid/x, match/armed, and clear/match_count when built
//              with the counter)
// Build option: define SEQ_PATTERN_DETECTOR_COUNT_EN to add the saturating
// match counter together with the clear and match_count signals.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_pattern_detector_if.slave  bus
);

    if ((W < W_MIN) || (W > W_MAX)) begin : g_bad_w
        $error("seq_pattern_detector: W out of range");
    end
    if ((CNT_W < 1) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
        $error("seq_pattern_detector: CNT_W out of range");
    end

    // Fill counts 0..W, so it needs enough bits to hold W itself.
    localparam int                FILL_W    = $clog2(W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [W-1:0]      pat_r;
    det_mode_e         mode_r;
    logic [W-1:0]      hist_r;
    logic [FILL_W-1:0] fill_r;
    logic              match_r;
    logic              armed_r;

    logic [W-1:0]      pat_next_s;
    det_mode_e         mode_next_s;
    logic [W-1:0]      hist_next_s;
    logic [FILL_W-1:0] fill_next_s;
    logic [W-1:0]      hist_shift_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic              hit_s;

    // Candidate post-shift history and saturating fill for a sampled bit.
    always_comb begin
        hist_shift_s = {hist_r[W-2:0], bus.x};
        if (fill_r == FILL_FULL) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + FILL_ONE;
        end
    end

    // Next state: load beats sampling; a hit is judged on post-shift values.
    always_comb begin
        pat_next_s  = pat_r;
        mode_next_s = mode_r;
        hist_next_s = hist_r;
        fill_next_s = fill_r;
        hit_s       = 1'b0;
        if (bus.load) begin
            pat_next_s  = bus.pattern;
            mode_next_s = det_mode_e'(bus.overlap);
            hist_next_s = {W{1'b0}};
            fill_next_s = {FILL_W{1'b0}};
        end else if (bus.in_valid) begin
            hist_next_s = hist_shift_s;
            fill_next_s = fill_inc_s;
            if ((fill_inc_s == FILL_FULL) && (hist_shift_s == pat_r)) begin
                hit_s = 1'b1;
                // Non-overlapping mode demands W fresh bits for the next hit.
                if (mode_r == MODE_NONOVERLAP) begin
                    fill_next_s = {FILL_W{1'b0}};
                end else begin
                    fill_next_s = fill_inc_s;
                end
            end else begin
                hit_s = 1'b0;
            end
        end else begin
            hit_s = 1'b0;
        end
    end

    // State and output registers; armed tracks the registered fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r   <= {W{1'b0}};
            mode_r  <= MODE_OVERLAP;
            hist_r  <= {W{1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            match_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            pat_r   <= pat_next_s;
            mode_r  <= mode_next_s;
            hist_r  <= hist_next_s;
            fill_r  <= fill_next_s;
            match_r <= hit_s;
            armed_r <= (fill_next_s == FILL_FULL);
        end
    end

    assign bus.match = match_r;
    assign bus.armed = armed_r;

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_s),
        .clr   (bus.clear),
        .count (bus.match_count)
    );
`endif

endmodule : seq_pattern_detector
